// File: rtl/register_write_arbiter_pkg.sv
// Shared constants for the register write arbiter.
// Widths, zero-register address and requester indices.
package register_write_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

    localparam int unsigned ZERO_REGISTER = 0;

    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_MEM  = 1'b1;

endpackage

// File: rtl/register_write_arbiter_saturating_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module saturating_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/register_write_arbiter.sv
// Two-requester register bank write arbiter.
// Alternating priority on contention, one registered write port.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [15:0]           conflict_count
);

    logic                  grant0;
    logic                  grant1;
    logic                  conflict;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  prio_d;
    logic                  prio_q;
    logic                  write_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] write_address_d;
    logic [ADDR_WIDTH-1:0] write_address_q;
    logic [DATA_WIDTH-1:0] write_data_d;
    logic [DATA_WIDTH-1:0] write_data_q;

    assign conflict = req0_valid && req1_valid;

    // Grant decode: lone requester wins, contention follows the pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            unique case (1'b1)
                (req0_valid && req1_valid): begin
                    grant0 = (prio_q == REQ_EXEC);
                    grant1 = (prio_q == REQ_MEM);
                end
                (req0_valid && !req1_valid): grant0 = 1'b1;
                (!req0_valid && req1_valid): grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign xfer        = grant0 || grant1;
    assign sel_address = grant1 ? req1_address : req0_address;
    assign sel_data    = grant1 ? req1_data : req0_data;

    // Next pointer and write port; writes to the zero register are dropped.
    always_comb begin
        prio_d          = prio_q;
        write_d         = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        if (conflict && xfer) begin
            prio_d = ~prio_q;
        end
        if (xfer && (sel_address != ADDR_WIDTH'(ZERO_REGISTER))) begin
            write_d         = 1'b1;
            write_address_d = sel_address;
            write_data_d    = sel_data;
        end
    end

    // Priority pointer and output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q          <= REQ_EXEC;
            write_q         <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            prio_q          <= prio_d;
            write_q         <= write_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    assign write         = write_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;

    saturating_counter #(
        .WIDTH (16)
    ) u_conflict_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (conflict),
        .count  (conflict_count)
    );

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter.
// Directed stimulus, expected writes checked by a queue-driven monitor.
module tb_register_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          write;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [15:0]   conflict_count;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] bank [32];
    int            n_checks = 0;
    int            n_fail = 0;

    register_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_address   (req0_address),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_address   (req1_address),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .write          (write),
        .write_address  (write_address),
        .write_data     (write_data),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h/%0h expected none",
                         write_address, write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(write_address), 64'(e.addr));
                chk("wr_data", 64'(write_data), 64'(e.data));
                bank[write_address] = write_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic v1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid   = v0;
        req0_address = a0;
        req0_data    = d0;
        req1_valid   = v1;
        req1_address = a1;
        req1_data    = d1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    logic exp_g [4];

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        exp_g[0] = 1'b0;
        exp_g[1] = 1'b1;
        exp_g[2] = 1'b0;
        exp_g[3] = 1'b1;

        reset = 1'b1;
        drive(1'b1, 5'd9, 32'h11, 1'b1, 5'd10, 32'h22);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        cyc();
        cyc();
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_waddr", 64'(write_address), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_cc", 64'(conflict_count), 64'd0);

        reset = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("single_ready0", 64'(req0_ready), 64'd1);
        chk("single_ready1", 64'(req1_ready), 64'd0);
        push(5'd5, 32'hDEADBEEF);
        cyc();
        idle();
        chk("single_write", 64'(write), 64'd1);
        chk("single_waddr", 64'(write_address), 64'd5);
        cyc();
        chk("single_pulse_end", 64'(write), 64'd0);
        chk("single_hold", 64'(write_address), 64'd5);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
            chk("alt_ready0", 64'(req0_ready), 64'(!exp_g[i]));
            chk("alt_ready1", 64'(req1_ready), 64'(exp_g[i]));
            if (exp_g[i]) push(5'd4, 32'd2);
            else push(5'd3, 32'd1);
            cyc();
        end
        idle();
        chk("alt_cc", 64'(conflict_count), 64'd4);

        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
        chk("zero_ready1", 64'(req1_ready), 64'd1);
        cyc();
        idle();
        cyc();
        chk("zero_nowrite", 64'(write), 64'd0);
        chk("zero_waddr", 64'(write_address), 64'd4);
        chk("zero_wdata", 64'(write_data), 64'd2);

        drive(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20);
        chk("same_ready0", 64'(req0_ready), 64'd1);
        chk("same_ready1", 64'(req1_ready), 64'd0);
        push(5'd7, 32'd10);
        cyc();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'd20);
        chk("same_ready1b", 64'(req1_ready), 64'd1);
        push(5'd7, 32'd20);
        cyc();
        idle();
        cyc();
        cyc();
        chk("same_bank7", 64'(bank[7]), 64'd20);
        chk("same_cc", 64'(conflict_count), 64'd5);

        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
        chk("pre_rst_ready1", 64'(req1_ready), 64'd1);
        push(5'd4, 32'd2);
        cyc();
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
        chk("pre_rst_ready0", 64'(req0_ready), 64'd1);
        push(5'd3, 32'd1);
        cyc();
        chk("pre_rst_cc", 64'(conflict_count), 64'd7);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready0", 64'(req0_ready), 64'd0);
        chk("mid_rst_ready1", 64'(req1_ready), 64'd0);
        cyc();
        chk("mid_rst_write", 64'(write), 64'd0);
        chk("mid_rst_waddr", 64'(write_address), 64'd0);
        chk("mid_rst_wdata", 64'(write_data), 64'd0);
        chk("mid_rst_cc", 64'(conflict_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready0", 64'(req0_ready), 64'd1);
        chk("post_rst_ready1", 64'(req1_ready), 64'd0);
        push(5'd3, 32'd1);
        cyc();

        drive(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
        repeat (65533) cyc();
        chk("sat_below", 64'(conflict_count), 64'hFFFE);
        repeat (3) cyc();
        chk("sat_top", 64'(conflict_count), 64'hFFFF);
        idle();
        cyc();
        chk("sat_hold", 64'(conflict_count), 64'hFFFF);
        chk("sat_nowrite", 64'(write), 64'd0);

        cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
